// File: rtl/inactivity_watchdog.sv
// Inactivity watchdog: prescaled tick timebase, button/kick idle counter, warning and
// fixed-width timeout reset pulse. Define WDT_DEBOUNCE_EN to debounce the synchronised buttons.
module inactivity_watchdog #(
  parameter int unsigned CLK_HZ     = 4000000,
  parameter int unsigned TICK_HZ    = 1,
  parameter int unsigned N_BTN      = 3,
  parameter int unsigned TIMEOUT_S  = 10,
  parameter int unsigned WARN_S     = 2,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned DEB_CYCLES = 8
) (
  input  logic                           i_clk_in,
  input  logic                           i_reset_n,
  input  logic                           i_enable,
  input  logic [N_BTN-1:0]               i_btn,
  input  logic                           i_kick,
  output logic                           o_tick,
  output logic                           o_tick_sq,
  output logic [$clog2(TIMEOUT_S+1)-1:0] o_sec_cnt,
  output logic                           o_warn,
  output logic                           o_rst_out,
  output logic [7:0]                     o_expire_cnt
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW  = $clog2(TIMEOUT_S + 1);
  localparam int unsigned FW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {StRun, StWarn, StFire} state_e;

  logic [PW-1:0]    r_pcnt, w_pcnt_d;
  logic             r_tick_sq, w_tick;
  logic [N_BTN-1:0] r_sync1, r_sync2, w_btn_act;
  logic             w_activity;
  state_e           r_state, w_state_d;
  logic [SW-1:0]    r_sec, w_sec_d, w_sec_inc;
  logic [FW-1:0]    r_fire, w_fire_d;
  logic             r_rst_out, w_rst_d, r_warn;
  logic [7:0]       r_exp, w_exp_d;

  // Free-running prescaler; never realigned by activity.
  assign w_tick   = (r_pcnt == PW'(DIV - 1));
  assign w_pcnt_d = w_tick ? '0 : r_pcnt + 1'b1;

  always_ff @(posedge i_clk_in or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pcnt    <= '0;
      r_tick_sq <= 1'b0;
      r_sync1   <= '0;
      r_sync2   <= '0;
    end else begin
      r_pcnt    <= w_pcnt_d;
      r_tick_sq <= (w_pcnt_d >= PW'(DIV / 2));
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
    end
  end

`ifdef WDT_DEBOUNCE_EN
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  logic [N_BTN-1:0]         r_deb;
  logic [N_BTN-1:0][DW-1:0] r_deb_cnt;

  // Debounced bit follows the synchroniser only after DEB_CYCLES consecutive differing cycles.
  always_ff @(posedge i_clk_in or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_deb     <= '0;
      r_deb_cnt <= '0;
    end else begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
            r_deb[i]     <= r_sync2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_btn_act = r_deb;
`else
  assign w_btn_act = r_sync2;
`endif

  assign w_activity = (|w_btn_act) | i_kick;
  assign w_sec_inc  = r_sec + 1'b1;

  always_comb begin
    w_state_d = r_state;
    w_sec_d   = r_sec;
    w_fire_d  = r_fire;
    w_rst_d   = r_rst_out;
    w_exp_d   = r_exp;
    unique case (r_state)
      StRun, StWarn: begin
        if (!i_enable || w_activity) begin
          w_sec_d   = '0;
          w_state_d = StRun;
        end else if (w_tick) begin
          if (r_sec == SW'(TIMEOUT_S - 1)) begin
            w_state_d = StFire;
            w_sec_d   = '0;
            w_fire_d  = '0;
            w_rst_d   = 1'b1;
            w_exp_d   = (r_exp == 8'hFF) ? r_exp : r_exp + 8'd1;
          end else begin
            w_sec_d   = w_sec_inc;
            w_state_d = (w_sec_inc >= SW'(TIMEOUT_S - WARN_S)) ? StWarn : StRun;
          end
        end
      end
      StFire: begin
        // Pulse always runs to completion regardless of enable, ticks or activity.
        if (r_fire == FW'(RST_CYCLES - 1)) begin
          w_state_d = StRun;
          w_rst_d   = 1'b0;
          w_fire_d  = '0;
        end else begin
          w_fire_d = r_fire + 1'b1;
        end
      end
      default: begin
        w_state_d = StRun;
        w_sec_d   = '0;
        w_rst_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk_in or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= StRun;
      r_sec     <= '0;
      r_fire    <= '0;
      r_rst_out <= 1'b0;
      r_warn    <= 1'b0;
      r_exp     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_sec     <= w_sec_d;
      r_fire    <= w_fire_d;
      r_rst_out <= w_rst_d;
      r_warn    <= (w_state_d == StWarn);
      r_exp     <= w_exp_d;
    end
  end

  assign o_tick       = w_tick;
  assign o_tick_sq    = r_tick_sq;
  assign o_sec_cnt    = r_sec;
  assign o_warn       = r_warn;
  assign o_rst_out    = r_rst_out;
  assign o_expire_cnt = r_exp;

endmodule
